// File: rtl/rv_pkg.sv
// Shared definitions between the EX controller and its functional units.
package rv_pkg;

  // Multiply operation select, driven by the EX controller.
  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mulctl_e;

  // EX result-source select.
  typedef enum logic [1:0] {
    IFURES_ALU = 2'b00,
    IFURES_MUL = 2'b01,
    IFURES_LSU = 2'b10,
    IFURES_CSR = 2'b11
  } ifuresctl_e;

  // Multiplier sequencer states.
  typedef enum logic [1:0] {
    MS_IDLE = 2'b00,
    MS_CALC = 2'b01,
    MS_DONE = 2'b10
  } mul_state_e;

endpackage

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for the EX stage.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | XLEN shift-add steps, then one sign-fixup/writeback cycle
// DONE  | one-cycle result strobe; start here re-issues back-to-back
module mul_unit
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mulctl,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            mulvalid,
  output logic [XLEN-1:0] mulres
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN);
  localparam logic [XLEN-1:0]   ONE_X    = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE_2X   = (2 * XLEN)'(1);

  mul_state_e        state;
  mulctl_e           op;
  logic              neg;
  logic [XLEN-1:0]   mplier;
  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;

  logic              s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   res;

  // Operand sign extraction and magnitudes; the most-negative value maps to 2^(XLEN-1) unsigned.
  always_comb begin
    s1 = 1'b0;
    s2 = 1'b0;
    unique case (mulctl)
      MUL, MULH: begin
        s1 = rs1[XLEN-1];
        s2 = rs2[XLEN-1];
      end
      MULHSU:  s1 = rs1[XLEN-1];
      default: ;
    endcase
    mag1 = s1 ? (~rs1 + ONE_X) : rs1;
    mag2 = s2 ? (~rs2 + ONE_X) : rs2;
  end

  // One shift-add step, plus the final sign fixup and word select.
  always_comb begin
    acc_step = mplier[0] ? (acc + mcand) : acc;
    prod     = neg ? (~acc + ONE_2X) : acc;
    res      = (op == MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  assign busy = (state == MS_CALC);

  // Sequencer and datapath registers; flush and reset both drop the operation silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= MS_IDLE;
      op       <= MUL;
      neg      <= 1'b0;
      mplier   <= '0;
      mcand    <= '0;
      acc      <= '0;
      cnt      <= '0;
      mulvalid <= 1'b0;
      mulres   <= '0;
    end else begin
      mulvalid <= 1'b0;
      if (flush) begin
        state <= MS_IDLE;
      end else begin
        unique case (state)
          MS_IDLE, MS_DONE: begin
            if (start) begin
              op     <= mulctl_e'(mulctl);
              neg    <= s1 ^ s2;
              mcand  <= {{XLEN{1'b0}}, mag1};
              mplier <= mag2;
              acc    <= '0;
              cnt    <= '0;
              state  <= MS_CALC;
            end else begin
              state <= MS_IDLE;
            end
          end
          MS_CALC: begin
            if (cnt == CNT_LAST) begin
              acc      <= prod;
              mulres   <= res;
              mulvalid <= 1'b1;
              state    <= MS_DONE;
            end else begin
              acc    <= acc_step;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
              cnt    <= cnt + 1'b1;
            end
          end
          default: state <= MS_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: vector table plus hand-written corner sequences.
module tb_mul_unit;
  import rv_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = 33;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [1:0]      mulctl;
  logic [XLEN-1:0] rs1, rs2;
  logic            flush;
  logic            busy;
  logic            mulvalid;
  logic [XLEN-1:0] mulres;

  int n_checks = 0;
  int n_fail   = 0;

  mul_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mulctl(mulctl),
    .rs1(rs1), .rs2(rs2), .flush(flush),
    .busy(busy), .mulvalid(mulvalid), .mulres(mulres)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and let the next edge accept it.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mulctl = op;
    rs1    = a;
    rs2    = b;
    tick();
    start = 1'b0;
  endtask

  // Count edges after acceptance until mulvalid shows up (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      lat++;
      if (mulvalid === 1'b1) return;
    end
    lat = -1;
  endtask

  // Count mulvalid pulses over a window; used where none must appear.
  task automatic count_valid(input int cycles, output int pulses);
    pulses = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (mulvalid === 1'b1) pulses++;
    end
  endtask

  int lat, pulses;
  logic [31:0] last_res;

  initial begin
    vecs[0]  = '{MUL,    32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{MULH,   32'h80000000,   32'h80000000, 32'h40000000};
    vecs[2]  = '{MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{MUL,    32'd3,          32'd4,        32'h0000000C};
    vecs[5]  = '{MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000};
    vecs[6]  = '{MULH,   32'h80000000,   32'h00000001, 32'hFFFFFFFF};
    vecs[7]  = '{MUL,    32'h80000000,   32'h80000000, 32'h00000000};
    vecs[8]  = '{MULHU,  32'h80000000,   32'h00000002, 32'h00000001};
    vecs[9]  = '{MULHSU, 32'h80000000,   32'hFFFFFFFF, 32'h80000000};
    vecs[10] = '{MUL,    32'h12345678,   32'h00000010, 32'h23456780};
    vecs[11] = '{MULHU,  32'h12345678,   32'h00000010, 32'h00000001};
    vecs[12] = '{MULH,   32'hFFFFFFFE,   32'h00000003, 32'hFFFFFFFF};
    vecs[13] = '{MUL,    32'h00000000,   32'hDEADBEEF, 32'h00000000};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    mulctl = 2'b00; rs1 = '0; rs2 = '0;
    tick(); tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_valid", {31'd0, mulvalid}, 32'd0);
    check("reset_res", mulres, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table: even entries issue back-to-back from DONE, odd ones from IDLE.
    for (int i = 0; i < 14; i++) begin
      if (i % 2 == 1) tick();
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd1);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), lat, LAT);
      check($sformatf("vec%0d_res", i), mulres, vecs[i].exp);
      check($sformatf("vec%0d_busy_done", i), {31'd0, busy}, 32'd0);
    end
    last_res = vecs[13].exp;
    tick();
    check("valid_one_cycle", {31'd0, mulvalid}, 32'd0);

    // start during CALC with other operands must be ignored.
    issue(MUL, 32'd7, 32'hFFFFFFFD);
    for (int k = 0; k < 4; k++) tick();
    start = 1'b1; mulctl = MULHU; rs1 = 32'hFFFFFFFF; rs2 = 32'h00001234;
    tick();
    start = 1'b0;
    wait_valid(lat);
    check("ignore_start_latency", lat, LAT - 5);
    check("ignore_start_res", mulres, 32'hFFFFFFEB);

    // start in DONE: next result LAT cycles after that acceptance.
    issue(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_valid(lat);
    check("b2b_latency", lat, LAT);
    check("b2b_res", mulres, 32'hFFFFFFFE);
    last_res = 32'hFFFFFFFE;
    tick();

    // flush mid-CALC.
    issue(MUL, 32'd3, 32'd4);
    for (int k = 0; k < 9; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_valid", {31'd0, mulvalid}, 32'd0);
    check("flush_res_kept", mulres, last_res);
    count_valid(45, pulses);
    check("flush_no_pulse", pulses, 0);

    // flush wins over simultaneous start.
    flush = 1'b1; start = 1'b1; mulctl = MUL; rs1 = 32'd5; rs2 = 32'd5;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_vs_start_busy", {31'd0, busy}, 32'd0);
    count_valid(40, pulses);
    check("flush_vs_start_no_pulse", pulses, 0);

    // Reset mid-CALC.
    issue(MULH, 32'h80000000, 32'h80000000);
    for (int k = 0; k < 11; k++) tick();
    rst_n = 1'b0;
    tick();
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_valid", {31'd0, mulvalid}, 32'd0);
    check("rst_mid_res", mulres, 32'd0);
    rst_n = 1'b1;
    count_valid(40, pulses);
    check("rst_mid_no_pulse", pulses, 0);
    issue(MUL, 32'd3, 32'd4);
    wait_valid(lat);
    check("post_rst_latency", lat, LAT);
    check("post_rst_res", mulres, 32'h0000000C);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
